// File: rtl/mcnay_counter_if.sv
// Bus bundle for mcnay_counter: load value, load strobe, increment enable
// and the registered count output.
interface mcnay_counter_if #(
  parameter int nbits = 16
);
  logic [nbits-1:0] in_num;
  logic             latch_val;
  logic             en;
  logic [nbits-1:0] out_num;

  // The controlling side drives load/enable and observes the count.
  modport master (
    output in_num,
    output latch_val,
    output en,
    input  out_num
  );

  // The counter samples load/enable and drives the count.
  modport slave (
    input  in_num,
    input  latch_val,
    input  en,
    output out_num
  );
endinterface

// File: rtl/mcnay_counter.sv
// Loadable up-counter that steps a trial value (candidate or divisor) for the
// prime-detection datapath. The output comes straight from the count register,
// so downstream compare/divide logic sees a value that is stable all cycle.
module mcnay_counter #(
  parameter int nbits = 16
) (
  input  logic            clk,
  input  logic            rst,
  mcnay_counter_if.slave  bus
);

  logic [nbits-1:0] cnt_reg;

  // Priority: reset, then load (loaded value is not incremented), then
  // increment with silent wrap, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (bus.latch_val) begin
      cnt_reg <= bus.in_num;
    end else if (bus.en) begin
      cnt_reg <= cnt_reg + {{(nbits-1){1'b0}}, 1'b1};
    end
  end

  assign bus.out_num = cnt_reg;

endmodule

// File: tb/tb_mcnay_counter.sv
// Self-checking bench for mcnay_counter: each driven cycle pushes its expected
// count onto a scoreboard queue, which is popped and compared after the edge.
module tb_mcnay_counter;

  localparam int nbits = 16;

  typedef struct {
    string            tag;
    logic [nbits-1:0] exp;
  } sb_entry_t;

  logic clk = 1'b0;
  logic rst;

  mcnay_counter_if #(.nbits(nbits)) bus ();

  mcnay_counter #(.nbits(nbits)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  sb_entry_t        sb_q[$];
  int               checks = 0;
  int               errors = 0;
  logic [nbits-1:0] model_cnt;

  task automatic check(input string tag, input logic [nbits-1:0] got,
                       input logic [nbits-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: out_num=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected result, then compare
  // one time unit after the edge.
  task automatic step(input string tag, input logic r, input logic l,
                      input logic e, input logic [nbits-1:0] din,
                      input logic [nbits-1:0] exp);
    sb_entry_t ent;
    rst           = r;
    bus.latch_val = l;
    bus.en        = e;
    bus.in_num    = din;
    ent.tag = tag;
    ent.exp = exp;
    sb_q.push_back(ent);
    model_cnt = exp;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty at compare, out_num=%h", tag, bus.out_num);
    end else begin
      ent = sb_q.pop_front();
      $display("[%0t] %-10s rst=%b ld=%b en=%b in=%h -> out=%h exp=%h",
               $time, ent.tag, r, l, e, din, bus.out_num, ent.exp);
      check(ent.tag, bus.out_num, ent.exp);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic             r, l, e;
    logic [nbits-1:0] din, exp;

    rst           = 1'b1;
    bus.latch_val = 1'b0;
    bus.en        = 1'b0;
    bus.in_num    = '0;
    @(negedge clk);

    // Reset overrides load and enable.
    step("reset0", 1, 1, 1, 16'h1234, 16'h0000);
    step("reset1", 1, 1, 1, 16'h1234, 16'h0000);

    // Load then count.
    step("load5",  0, 1, 0, 16'd5, 16'd5);
    step("inc6",   0, 0, 1, 16'd0, 16'd6);
    step("inc7",   0, 0, 1, 16'd0, 16'd7);
    step("inc8",   0, 0, 1, 16'd0, 16'd8);

    // Hold with enable low.
    for (int i = 0; i < 4; i++) step("hold8", 0, 0, 0, 16'hABCD, 16'd8);
    step("inc9",   0, 0, 1, 16'd0, 16'd9);

    // Load has priority over enable; loaded value not incremented.
    step("prio100", 0, 1, 1, 16'd100, 16'd100);
    step("inc101",  0, 0, 1, 16'd0,   16'd101);

    // Wrap-around.
    step("ldFFFE", 0, 1, 0, 16'hFFFE, 16'hFFFE);
    step("incFFFF", 0, 0, 1, 16'h0, 16'hFFFF);
    step("wrap0",  0, 0, 1, 16'h0, 16'h0000);
    step("wrap1",  0, 0, 1, 16'h0, 16'h0001);

    // Reset mid-count.
    step("ld40",   0, 1, 0, 16'h0040, 16'h0040);
    step("inc41",  0, 0, 1, 16'h0,    16'h0041);
    step("inc42",  0, 0, 1, 16'h0,    16'h0042);
    step("rstmid", 1, 1, 1, 16'h5555, 16'h0000);
    step("after1", 0, 0, 1, 16'h0,    16'h0001);

    // Random mix against a priority model of the counter.
    for (int i = 0; i < 60; i++) begin
      r   = ($urandom_range(0, 15) == 0);
      l   = ($urandom_range(0, 5) == 0);
      e   = ($urandom_range(0, 3) != 0);
      din = (i % 7 == 0) ? 16'hFFFF : nbits'($urandom);
      if (r)      exp = '0;
      else if (l) exp = din;
      else if (e) exp = model_cnt + 16'd1;
      else        exp = model_cnt;
      step("rand", r, l, e, din, exp);
    end

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
